// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Brief    : Instruction-fetch stage with IF/ID register, stall buffer and
//            flush redirect, including draining of in-flight memory requests.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc4_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] ibuf_q, ibuf_d;
    logic [31:0] ibuf_pc4_q, ibuf_pc4_d;
    logic [31:0] addr_plus4;

    assign addr_plus4 = addr_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        ibuf_d     = ibuf_q;
        ibuf_pc4_d = ibuf_pc4_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                    addr_d  = pc_q;
                end
            end
            S_FETCH: begin
                if (imem_ack_i) begin
                    if (flush_i) begin
                        pc_d    = branch_target_i;
                        addr_d  = branch_target_i;
                        valid_d = 1'b0;
                    end else if (stall_i) begin
                        ibuf_d     = imem_rdata_i;
                        ibuf_pc4_d = addr_plus4;
                        pc_d       = addr_plus4;
                        state_d    = S_HOLD;
                    end else begin
                        instr_d = imem_rdata_i;
                        pc4_d   = addr_plus4;
                        valid_d = 1'b1;
                        pc_d    = addr_plus4;
                        addr_d  = addr_plus4;
                    end
                end else if (flush_i) begin
                    // Request stays on the bus; its data is dropped in DRAIN.
                    pc_d    = branch_target_i;
                    valid_d = 1'b0;
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (flush_i) begin
                    pc_d    = branch_target_i;
                    addr_d  = branch_target_i;
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end else if (!stall_i) begin
                    instr_d = ibuf_q;
                    pc4_d   = ibuf_pc4_q;
                    valid_d = 1'b1;
                    addr_d  = pc_q;
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (flush_i) begin
                    pc_d = branch_target_i;
                end
                if (imem_ack_i) begin
                    addr_d  = flush_i ? branch_target_i : pc_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            pc_q       <= 32'd0;
            addr_q     <= 32'd0;
            valid_q    <= 1'b0;
            instr_q    <= 32'd0;
            pc4_q      <= 32'd0;
            ibuf_q     <= 32'd0;
            ibuf_pc4_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            ibuf_q     <= ibuf_d;
            ibuf_pc4_q <= ibuf_pc4_d;
        end
    end

    assign imem_req_o   = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign imem_addr_o  = addr_q;
    assign pc_o         = pc_q;
    assign ifid_valid_o = valid_q;
    assign ifid_instr_o = instr_q;
    assign ifid_pc4_o   = pc4_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_stage
// Brief    : Randomized scoreboard bench for if_fetch_stage with a
//            transaction-level fetch model and a latency-randomized memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, start, stall, flush, ack;
    logic [31:0] tgt, rdata;
    logic        req, valid;
    logic [31:0] addr, pc, instr, pc4;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
        .flush_i(flush), .branch_target_i(tgt),
        .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack),
        .imem_rdata_i(rdata), .pc_o(pc), .ifid_valid_o(valid),
        .ifid_instr_o(instr), .ifid_pc4_o(pc4)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch stream as flags plus queues of expected
    // request addresses and expected IF/ID deliveries {instr, pc4}.
    bit          m_run, m_hold, m_kill, m_valid;
    logic [31:0] m_pc, m_addr, m_buf, m_bufpc4;
    logic [31:0] req_q[$];
    logic [63:0] exp_q[$];

    task automatic issue(input logic [31:0] a);
        m_addr = a;
        req_q.push_back(a);
    endtask

    task automatic model_step();
        if (rst) begin
            m_run = 0; m_hold = 0; m_kill = 0; m_valid = 0;
            m_pc = 0; m_addr = 0; m_buf = 0; m_bufpc4 = 0;
            req_q.delete();
            exp_q.delete();
        end else if (!m_run) begin
            if (start) begin
                m_run = 1;
                issue(m_pc);
            end
        end else if (m_hold) begin
            if (flush) begin
                m_hold = 0; m_pc = tgt; m_valid = 0;
                issue(tgt);
            end else if (!stall) begin
                m_hold = 0; m_valid = 1;
                exp_q.push_back({m_buf, m_bufpc4});
                issue(m_pc);
            end
        end else if (m_kill) begin
            if (flush) m_pc = tgt;
            if (ack) begin
                m_kill = 0;
                issue(m_pc);
            end
        end else if (ack) begin
            if (flush) begin
                m_pc = tgt; m_valid = 0;
                issue(tgt);
            end else if (stall) begin
                m_buf = rdata; m_bufpc4 = m_addr + 32'd4;
                m_pc = m_addr + 32'd4; m_hold = 1;
            end else begin
                exp_q.push_back({rdata, m_addr + 32'd4});
                m_valid = 1;
                m_pc = m_addr + 32'd4;
                issue(m_pc);
            end
        end else if (flush) begin
            m_pc = tgt; m_valid = 0; m_kill = 1;
        end
    endtask

    always @(posedge clk) model_step();

    // Memory responder + monitor, both working mid-cycle.
    int          lat_min = 0, lat_max = 0, cnt = 0, cur_lat = 0;
    bit          tbl_mode = 1;
    bit          p_valid = 0;
    logic [31:0] p_pc4 = 0, p_instr = 0;

    task automatic monitor();
        logic [63:0] e;
        check("req", 32'(req), 32'(m_run && !m_hold));
        check("pc", pc, m_pc);
        check("addr", addr, m_addr);
        check("valid", 32'(valid), 32'(m_valid));
        if (valid && (!p_valid || pc4 !== p_pc4 || instr !== p_instr)) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_delivery: got instr %08h pc4 %08h, none expected", instr, pc4);
            end else begin
                e = exp_q.pop_front();
                check("ifid_instr", instr, e[63:32]);
                check("ifid_pc4", pc4, e[31:0]);
            end
        end
        check("pending_deliveries", 32'(exp_q.size()), 32'd0);
        p_valid = valid; p_pc4 = pc4; p_instr = instr;
    endtask

    task automatic memory();
        logic [31:0] a;
        if (req && !rst) begin
            if (cnt >= cur_lat) begin
                ack   = 1'b1;
                rdata = tbl_mode ? ((addr >> 2) + 32'd1) * 32'h11 : $urandom;
                if (req_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL handshake: got addr %08h, no request expected", addr);
                end else begin
                    a = req_q.pop_front();
                    check("hs_addr", addr, a);
                end
                cnt     = 0;
                cur_lat = int'($urandom_range(lat_max, lat_min));
            end else begin
                ack = 1'b0;
                cnt++;
            end
        end else begin
            ack     = 1'b0;
            rdata   = $urandom;
            cnt     = 0;
            cur_lat = int'($urandom_range(lat_max, lat_min));
        end
    endtask

    always @(negedge clk) begin
        monitor();
        memory();
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; start = 0; stall = 0; flush = 0; tgt = 0; ack = 0; rdata = 0;
        repeat (3) cyc();
        check("rst_req", 32'(req), 0);
        check("rst_addr", addr, 0);
        check("rst_pc", pc, 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_instr", instr, 0);
        check("rst_pc4", pc4, 0);

        // Zero-wait streaming from address 0.
        rst = 0; start = 1;
        cyc();
        check("start_addr", addr, 0);
        check("start_req", 32'(req), 1);
        start = 0;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            check("zw_instr", instr, 32'h11 * i);
            check("zw_pc4", pc4, 4 * i);
            check("zw_addr", addr, 4 * i);
        end

        // Randomized traffic with stalls, flushes, resets and latency.
        tbl_mode = 0; lat_max = 3;
        for (int i = 0; i < 4000; i++) begin
            cyc();
            rst   = ($urandom_range(299, 0) == 0);
            start = 1'($urandom_range(1, 0));
            stall = ($urandom_range(9, 0) < 3);
            flush = ($urandom_range(11, 0) == 0);
            tgt   = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF8 : $urandom;
        end

        // PC wrap at the top of the address space.
        rst = 1; start = 0; stall = 0; flush = 0; lat_min = 0; lat_max = 0;
        cyc();
        rst = 0; start = 1;
        cyc();
        start = 0; flush = 1; tgt = 32'hFFFF_FFFC;
        cyc();
        check("wrap_redirect", addr, 32'hFFFF_FFFC);
        check("wrap_valid0", 32'(valid), 0);
        flush = 0;
        cyc();
        check("wrap_addr", addr, 32'h0);
        check("wrap_pc4", pc4, 32'h0);
        check("wrap_valid1", 32'(valid), 1);

        // Flush while a slow request is pending, then reset inside DRAIN.
        rst = 1;
        cyc();
        rst = 0; lat_min = 4; lat_max = 4; start = 1;
        cyc();
        start = 0; flush = 1; tgt = 32'h100;
        cyc();
        check("drain_addr", addr, 32'h0);
        check("drain_pc", pc, 32'h100);
        check("drain_req", 32'(req), 1);
        flush = 0; rst = 1;
        cyc();
        check("drst_req", 32'(req), 0);
        check("drst_addr", addr, 0);
        check("drst_pc", pc, 0);
        check("drst_valid", 32'(valid), 0);
        rst = 0;
        cyc();
        check("drst_idle", 32'(req), 0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_i input 1, rising-edge clock for all state; rst_i input 1, synchronous active-high reset.
REQ-002 start_i  input  1  CPU run enable; sampled only in IDLE.
REQ-003 stall_i  input  1  hazard hold: freeze the IF/ID outputs and stop fetch advance.
REQ-004 flush_i  input  1  branch/jump taken in ID: discard the fetched instruction and redirect to branch_target_i.
REQ-005 branch_target_i  input  32  redirect address; valid only when flush_i=1.
REQ-006 imem_req_o  output  1  instruction memory request.
REQ-007 imem_addr_o  output  32  request address; held stable from request start until ack.
REQ-008 imem_ack_i  input  1  one-cycle ack; may arrive in the same cycle as imem_req_o (zero-wait) or any later cycle.
REQ-009 imem_rdata_i  input  32  instruction word; valid only in the cycle imem_ack_i=1.
REQ-010 pc_o  output  32  next fetch PC, registered.
REQ-011 ifid_valid_o  output  1  IF/ID slot holds a real instruction.
REQ-012 ifid_instr_o  output  32  IF/ID instruction.
REQ-013 ifid_pc4_o  output  32  IF/ID fetch address+4.

Function
REQ-014 The block SHALL use states IDLE, FETCH, HOLD and DRAIN; imem_req_o=1 only in FETCH and DRAIN.
REQ-015 IDLE: start_i=1 -> FETCH next cycle with imem_addr_o<=pc_o; otherwise stay in IDLE.
REQ-016 FETCH, ack, flush_i=1: discard rdata; pc_o<=branch_target_i; imem_addr_o<=branch_target_i; ifid_valid_o<=0; stay in FETCH.
REQ-017 FETCH, ack, flush_i=0, stall_i=1: buffer<=rdata; buffer_pc4<=addr+4; pc_o<=addr+4; IF/ID unchanged; go to HOLD.
REQ-018 FETCH, ack, neither flush_i nor stall_i: ifid_instr_o<=rdata; ifid_pc4_o<=addr+4; ifid_valid_o<=1; pc_o and imem_addr_o<=addr+4; stay in FETCH, giving 1 instruction/cycle at zero wait.
REQ-019 FETCH, no ack, flush_i=1: pc_o<=branch_target_i; ifid_valid_o<=0; imem_addr_o unchanged; go to DRAIN.
REQ-020 FETCH, no ack, flush_i=0: all registers hold, whether or not stall_i=1.
REQ-021 HOLD: flush_i=1 -> discard buffer; pc_o and imem_addr_o<=branch_target_i; ifid_valid_o<=0; go to FETCH.
REQ-022 HOLD: stall_i=1 (no flush) -> hold all registers.
REQ-023 HOLD: otherwise IF/ID<=buffer/buffer_pc4 with ifid_valid_o<=1; imem_addr_o<=pc_o; go to FETCH.
REQ-024 DRAIN: imem_addr_o holds the stale address; on ack, discard rdata, imem_addr_o<=pc_o, go to FETCH.
REQ-025 DRAIN: flush_i=1 -> pc_o<=branch_target_i, with the newest flush winning, including when ack arrives in the same cycle.
REQ-026 flush_i SHALL take priority over stall_i in every state.
REQ-027 PC arithmetic SHALL be 32-bit unsigned, +4, wrapping 0xFFFFFFFC->0x00000000, with no alignment check.
REQ-028 start_i SHALL be ignored outside IDLE; an outstanding request always completes or drains.
REQ-029 A request SHALL never be abandoned: imem_req_o and imem_addr_o stay stable until ack.

Reset
REQ-030 rst_i=1 at a clock edge SHALL force IDLE with pc_o=0, imem_addr_o=0, imem_req_o=0, ifid_valid_o=0, ifid_instr_o=0, ifid_pc4_o=0, buffer=0, buffer_pc4=0.
REQ-031 Reset SHALL take precedence over all inputs, including mid-request; the in-flight ack is not tracked after reset.

Verification
REQ-032 Reset, then start_i=1, zero-wait ack returning 0x11,0x22,0x33 -> imem_addr_o 0,4,8; ifid_instr_o 0x11,0x22,0x33 on consecutive cycles; ifid_pc4_o 4,8,12.
REQ-033 Two-cycle ack latency -> imem_req_o high and imem_addr_o stable for 2 cycles per word; ifid_valid_o stays 1 and IF/ID holds between updates.
REQ-034 stall_i=1 for 3 cycles at an ack at addr 8 -> IF/ID frozen, state HOLD, imem_req_o=0; on release ifid_instr_o=word@8 and ifid_pc4_o=12, then fetch 12.
REQ-035 flush_i=1, branch_target_i=0x100 while a request to 0x10 is pending -> ifid_valid_o=0 next cycle; req stays at 0x10 until ack; that data is discarded; next request 0x100.
REQ-036 flush_i and stall_i both high at an ack -> flush wins: ifid_valid_o=0 and next imem_addr_o=target.
REQ-037 pc_o=0xFFFFFFFC fetched -> next imem_addr_o=0; rst_i asserted mid-DRAIN -> all outputs 0, IDLE next cycle.
